// File: rtl/lane_scheduler_if.sv
// Requester/serial-output bundle for lane_scheduler; the scheduler takes the slave side.
interface lane_scheduler_if;
  logic [7:0] Entrada0;
  logic [7:0] Entrada1;
  logic [7:0] Entrada2;
  logic [7:0] Entrada3;
  logic       validEntrada0;
  logic       validEntrada1;
  logic       validEntrada2;
  logic       validEntrada3;
  logic [3:0] lane_en;
  logic       retrain;
  logic [3:0] pop;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] grant_id;
  logic       active;
  logic       state_dbg;

  // Handshake: a byte on Entrada<i> is offered while validEntrada<i> is high and
  // is consumed at the rising edge where pop[i] is high; that byte appears on
  // data_out with valid_out=1 in the following cycle. valid_out has no ready.
  modport master (
    output Entrada0, Entrada1, Entrada2, Entrada3,
    output validEntrada0, validEntrada1, validEntrada2, validEntrada3,
    output lane_en, retrain,
    input  pop, data_out, valid_out, grant_id, active, state_dbg
  );

  modport slave (
    input  Entrada0, Entrada1, Entrada2, Entrada3,
    input  validEntrada0, validEntrada1, validEntrada2, validEntrada3,
    input  lane_en, retrain,
    output pop, data_out, valid_out, grant_id, active, state_dbg
  );
endinterface

// File: rtl/lane_scheduler.sv
// Four-lane round-robin serialiser with a comma-based training prologue.
module lane_scheduler #(
  parameter int         TRAIN_LEN = 4,
  parameter logic [7:0] COMMA     = 8'hBC
) (
  input  logic           clk_4f,
  input  logic           reset,
  lane_scheduler_if.slave bus
);

  typedef enum logic {TRAIN = 1'b0, ACTIVE = 1'b1} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [1:0] ptr;
  logic [7:0] data_q;
  logic       valid_q;
  logic [1:0] grant_q;
  logic       active_q;

  logic [3:0] req;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       any_req;
  logic       grant;
  logic [7:0] win_data;

  always_comb begin
    req = {bus.validEntrada3 & bus.lane_en[3], bus.validEntrada2 & bus.lane_en[2],
           bus.validEntrada1 & bus.lane_en[1], bus.validEntrada0 & bus.lane_en[0]};
    winner  = ptr;
    any_req = 1'b0;
    idx     = ptr;
    // Scan from the far end so the nearest requester to ptr is assigned last.
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

  assign grant   = reset && (state == ACTIVE) && !bus.retrain && any_req;
  assign bus.pop = grant ? (4'b0001 << winner) : 4'b0000;

  always_comb begin
    case (winner)
      2'd0:    win_data = bus.Entrada0;
      2'd1:    win_data = bus.Entrada1;
      2'd2:    win_data = bus.Entrada2;
      default: win_data = bus.Entrada3;
    endcase
  end

  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      state    <= TRAIN;
      cnt      <= 4'd0;
      ptr      <= 2'd0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      grant_q  <= 2'd0;
      active_q <= 1'b0;
    end else begin
      case (state)
        TRAIN: begin
          data_q  <= COMMA;
          valid_q <= 1'b0;
          if (bus.retrain) begin
            cnt <= 4'd0;
          end else if (cnt >= 4'(TRAIN_LEN - 1)) begin
            // >= keeps TRAIN_LEN=1 from wrapping after a retrain that preloads cnt=1.
            state    <= ACTIVE;
            active_q <= 1'b1;
            cnt      <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ACTIVE: begin
          if (bus.retrain) begin
            // The retrain edge itself is the first comma of the new sequence.
            state    <= TRAIN;
            active_q <= 1'b0;
            cnt      <= 4'd1;
            data_q   <= COMMA;
            valid_q  <= 1'b0;
          end else if (grant) begin
            data_q  <= win_data;
            valid_q <= 1'b1;
            grant_q <= winner;
            ptr     <= winner + 2'd1;
          end else begin
            data_q  <= COMMA;
            valid_q <= 1'b0;
          end
        end
        default: state <= TRAIN;
      endcase
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.grant_id  = grant_q;
  assign bus.active    = active_q;
  assign bus.state_dbg = state;

endmodule
